// File: rtl/atm_session_ctrl.sv
// Per-session ATM sequencer: card admission, password retries with lockout,
// and the inquiry/withdraw/deposit/exit menu with a one-cycle commit strobe.
module atm_session_ctrl #(
  parameter int card_width     = 6,
  parameter int password_width = 16,
  parameter int balance_width  = 20,
  parameter int users_num      = 10,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_inserted,
  input  logic [card_width-1:0]    card_number_in,
  input  logic                     psw_valid,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  input  logic [balance_width-1:0] balance,
  input  logic                     wrong_psw,
  output logic                     card_in,
  output logic [card_width-1:0]    card_number,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic                     txn_ok,
  output logic                     txn_reject,
  output logic                     card_locked,
  output logic                     eject,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PSW = 3'd1,
    S_CHECK    = 3'd2,
    S_VERIFY   = 3'd3,
    S_MENU     = 3'd4,
    S_EXEC     = 3'd5,
    S_EJECT    = 3'd6
  } state_t;

  localparam int TRY_W = $clog2(max_tries + 1);
  localparam int TMO_W = $clog2(timeout_cycles + 1);
  // Park address: one past the last valid card, so datapath writes are ignored.
  localparam logic [card_width-1:0] PARK = card_width'(users_num);

  // The park address must be representable and the password path must exist.
  if (users_num >= (1 << card_width) || password_width < 1) begin : g_bad_params
    $error("atm_session_ctrl: inconsistent parameters");
  end

  state_t                     state_q;
  logic [card_width-1:0]      card_q;
  logic [TRY_W-1:0]           tries_q;
  logic [TMO_W-1:0]           tmo_q;
  logic [users_num-1:0]       lock_q;
  logic [balance_width-1:0]   result_q;
  logic                       card_in_q, op_done_q, ok_q, rej_q, locked_q, eject_q;

  logic                       in_range, lock_hit, tmo_hit, last_try, res_ok;
  logic [balance_width:0]     sum;
  logic [balance_width-1:0]   res;

  assign in_range = (card_number_in < PARK);
  assign tmo_hit  = (int'(tmo_q) >= timeout_cycles - 1);
  assign last_try = (int'(tries_q) + 1 >= max_tries);

  // Look up the lock bit of the card currently in the reader.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    lock_hit = 1'b0;
    for (int i = 0; i < users_num; i++) begin
      if (card_number_in == card_width'(i)) lock_hit = lock_q[i];
    end
  end

  // New balance and verdict for the operation being requested from MENU.
  always_comb begin
    sum    = {1'b0, balance} + {1'b0, amount};
    res    = balance;
    res_ok = 1'b1;
    case (op_code)
      2'b01: begin
        if (amount <= balance) res = balance - amount;
        else res_ok = 1'b0;
      end
      2'b10: begin
        if (sum[balance_width]) res_ok = 1'b0;
        else res = sum[balance_width-1:0];
      end
      default: ;
    endcase
  end

  // Session FSM with its counters, lock bitmap and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the lock bitmap is small control state, so it is reset like every other flop.
      state_q   <= S_IDLE;
      card_q    <= PARK;
      tries_q   <= '0;
      tmo_q     <= '0;
      lock_q    <= '0;
      result_q  <= '0;
      card_in_q <= 1'b0;
      op_done_q <= 1'b0;
      ok_q      <= 1'b0;
      rej_q     <= 1'b0;
      locked_q  <= 1'b0;
      eject_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      op_done_q <= 1'b0;
      ok_q      <= 1'b0;
      rej_q     <= 1'b0;
      eject_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (card_inserted) begin
            if (in_range && !lock_hit) begin
              card_q  <= card_number_in;
              tries_q <= '0;
              tmo_q   <= '0;
              state_q <= S_WAIT_PSW;
            end else begin
              locked_q <= lock_hit;
              eject_q  <= 1'b1;
              state_q  <= S_EJECT;
            end
          end
        end
        S_WAIT_PSW: begin
          if (!card_inserted || (!psw_valid && tmo_hit)) begin
            eject_q <= 1'b1;
            state_q <= S_EJECT;
          end else if (psw_valid) begin
            card_in_q <= 1'b1;
            state_q   <= S_CHECK;
          end else if (int'(tmo_q) < timeout_cycles) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (!card_inserted) begin
            card_in_q <= 1'b0;
            eject_q   <= 1'b1;
            state_q   <= S_EJECT;
          end else begin
            state_q <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          // A final wrong attempt locks the card even if it is being pulled out.
          if (wrong_psw && last_try) begin
            for (int i = 0; i < users_num; i++) begin
              if (card_q == card_width'(i)) lock_q[i] <= 1'b1;
            end
            card_in_q <= 1'b0;
            locked_q  <= 1'b1;
            eject_q   <= 1'b1;
            state_q   <= S_EJECT;
          end else if (!card_inserted) begin
            card_in_q <= 1'b0;
            eject_q   <= 1'b1;
            state_q   <= S_EJECT;
          end else if (wrong_psw) begin
            tries_q   <= tries_q + 1'b1;
            tmo_q     <= '0;
            card_in_q <= 1'b0;
            state_q   <= S_WAIT_PSW;
          end else begin
            tries_q <= '0;
            tmo_q   <= '0;
            state_q <= S_MENU;
          end
        end
        S_MENU: begin
          if (!card_inserted || (op_valid && op_code == 2'b11) || (!op_valid && tmo_hit)) begin
            card_in_q <= 1'b0;
            eject_q   <= 1'b1;
            state_q   <= S_EJECT;
          end else if (op_valid) begin
            result_q  <= res;
            op_done_q <= 1'b1;
            ok_q      <= res_ok;
            rej_q     <= !res_ok;
            state_q   <= S_EXEC;
          end else if (int'(tmo_q) < timeout_cycles) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_EXEC: begin
          // The commit always completes; a pulled card is noticed back in MENU.
          tmo_q   <= '0;
          state_q <= S_MENU;
        end
        S_EJECT: begin
          if (!card_inserted) begin
            locked_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          card_in_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign card_in         = card_in_q;
  assign card_number     = card_in_q ? card_q : PARK;
  assign op_done         = op_done_q;
  assign updated_balance = op_done_q ? result_q : balance;
  assign txn_ok          = ok_q;
  assign txn_reject      = rej_q;
  assign card_locked     = locked_q;
  assign eject           = eject_q;
  assign state           = state_q;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Per-session sequencer for the card-handling datapath (password check plus balance store).
- Accepts a card, drives password verification with a bounded retry count, and locks a card after too many failures.
- Serves a menu of balance inquiry, withdraw, deposit and exit, computes the new balance, and commits it with a one-cycle op_done.
- Sits between the user-facing front panel and the card-handling datapath.

Parameters:
- card_width, 6: card number width.
- password_width, 16: password width. Passes through only; the controller does not use it internally.
- balance_width, 20: balance and amount width.
- users_num, 10: number of valid cards, numbered 0..users_num-1.
- max_tries, 3: wrong-password attempts allowed before lock.
- timeout_cycles, 255: idle cycles allowed in WAIT_PSW or MENU before forced eject.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-low reset.
- card_inserted, in, 1: level, card physically present.
- card_number_in, in, card_width: card number from the reader.
- psw_valid, in, 1: one-cycle pulse, user password presented and held stable by the panel.
- op_valid, in, 1: one-cycle pulse, operation request.
- op_code, in, 2: 00 inquiry, 01 withdraw, 10 deposit, 11 exit.
- amount, in, balance_width: transaction amount, sampled with op_valid.
- balance, in, balance_width: registered balance from the datapath.
- wrong_psw, in, 1: registered password-mismatch flag from the datapath.
- card_in, out, 1: to the datapath; enables the password check.
- card_number, out, card_width: to the datapath.
- op_done, out, 1: to the datapath; commit strobe.
- updated_balance, out, balance_width: to the datapath.
- txn_ok, out, 1: one-cycle pulse, operation succeeded.
- txn_reject, out, 1: one-cycle pulse, insufficient funds or deposit overflow.
- card_locked, out, 1: level, held during EJECT caused by a lock.
- eject, out, 1: one-cycle pulse on entry to EJECT.
- state, out, 3: current state encoding, for debug.

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0 except card_number, which goes to users_num (park address). FSM goes to IDLE. Tries counter, timeout counter and the users_num-bit lock bitmap clear. Reset asserted mid-session aborts the session; no op_done is issued.
- Park rule: whenever card_in=0, card_number=users_num, so the datapath ignores writes.
- Mirror rule: updated_balance=balance in every cycle op_done=0.
- card_in is 1 in CHECK, VERIFY, MENU and EXEC, and 0 otherwise.
- IDLE → WAIT_PSW: card_inserted=1, card_number_in<users_num, and lock bit clear. The card number is latched and tries=0.
- IDLE → EJECT: out-of-range card, or card already locked. card_locked=1 in the locked case.
- WAIT_PSW → CHECK: psw_valid.
- WAIT_PSW → EJECT: timeout reaches timeout_cycles.
- CHECK lasts 1 cycle (datapath samples the password) → VERIFY.
- VERIFY samples wrong_psw, which is valid one cycle after CHECK.
  - wrong_psw=0: tries=0 → MENU.
  - wrong_psw=1 and tries+1<max_tries: tries=tries+1 → WAIT_PSW.
  - wrong_psw=1 and tries+1=max_tries: lock bit set, card_locked=1 → EJECT.
- MENU → EXEC: op_valid with op_code≠11. op_code and amount are latched.
- MENU → EJECT: op_valid with op_code=11, or timeout.
- EXEC lasts 1 cycle, asserts op_done=1, then → MENU.
  - Inquiry: updated_balance=balance, txn_ok.
  - Withdraw: if amount≤balance then updated_balance=balance−amount with txn_ok; else updated_balance=balance with txn_reject.
  - Deposit: sum computed at balance_width+1 bits. On carry-out, updated_balance=balance with txn_reject; else updated_balance=sum with txn_ok.
- EJECT: eject pulse on the entry cycle. Stays in EJECT until card_inserted=0 → IDLE. card_locked clears on exit.
- Card removed mid-session (card_inserted=0 in WAIT_PSW, CHECK, VERIFY or MENU): → EJECT next cycle. An EXEC in progress completes its commit first.
- Timeout counter: counts only in WAIT_PSW and MENU. Clears on state entry and on psw_valid or op_valid. Saturating.
- psw_valid or op_valid arriving in states that do not consume them is ignored.

Test Plan:
- Reset mid-MENU (card 3) → next cycle: state=IDLE, card_in=0, card_number=10, op_done=0, all pulses 0.
- Card 2, correct password → CHECK, VERIFY, MENU. Withdraw 100 with balance=500 → EXEC: op_done=1, updated_balance=400, txn_ok=1. Back in MENU.
- Card 4, wrong password ×3 → lock bit 4 set, eject=1, card_locked=1. Card 4 reinserted → immediate EJECT with card_locked=1; WAIT_PSW is never entered.
- Withdraw 600 with balance=500 → op_done=1, updated_balance=500, txn_reject=1. Deposit 1 with balance=0xFFFFF → updated_balance=0xFFFFF, txn_reject=1.
- Card 12 (≥users_num) → EJECT; card_in stays 0; card_number stays 10.
- MENU idle 255 cycles → eject pulse; no op_done. Exit op_code=11 → EJECT; then card_inserted=0 → IDLE.
